// File: rtl/cdc_pulse_pacer.sv
// cdc_pulse_pacer: queues event pulses from several requesters, arbitrates them
// round-robin and issues them one at a time, spaced so a downstream toggle
// synchronizer can never drop or merge two events. Optionally waits for a
// return acknowledge (with timeout) before issuing the next event.
module cdc_pulse_pacer #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned USE_ACK     = 0,
    parameter int unsigned ACK_TIMEOUT = 64,
    localparam int unsigned IDW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req_pulse,
    input  logic               ovf_clear,
    input  logic               ack_pulse,
    output logic               issue_pulse,
    output logic [IDW-1:0]     issue_id,
    output logic               pending_any,
    output logic               busy,
    output logic [NUM_REQ-1:0] overflow,
    output logic               timeout_pulse
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt      [NUM_REQ];
    logic [CNT_W-1:0]   cnt_next [NUM_REQ];
    logic [NUM_REQ-1:0] ovf_next;
    logic               any_next;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_next;
    logic [ACK_W-1:0]   ack_cnt;
    logic [ACK_W-1:0]   ack_next;
    logic               ack_seen;
    logic               ack_seen_next;
    logic               issue_next;
    logic [IDW-1:0]     id_next;
    logic               timeout_next;
    logic               found;
    logic [IDW-1:0]     win;
    logic [NUM_REQ-1:0] grant;

    // Round-robin search: first nonzero count starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found && cnt[IDW'((32'(ptr) + k) % NUM_REQ)] != '0) begin
                found = 1'b1;
                win   = IDW'((32'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // One-hot grant, only when the pacer is free to issue.
    always_comb begin
        grant = '0;
        if (state == IDLE && found) begin
            grant[win] = 1'b1;
        end
    end

    // Per-requester pending counters with saturation and sticky overflow flags.
    always_comb begin
        any_next = 1'b0;
        ovf_next = overflow;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_next[i] = cnt[i];
            if (req_pulse[i] && !grant[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    ovf_next[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end else if (!req_pulse[i] && grant[i]) begin
                cnt_next[i] = cnt[i] - CNT_W'(1);
            end
            if (ovf_clear) begin
                ovf_next[i] = 1'b0;
            end
            any_next = any_next | (cnt_next[i] != '0);
        end
    end

    // Pacing FSM: next state, timers and registered-output next values.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        gap_next      = gap_cnt;
        ack_next      = ack_cnt;
        ack_seen_next = ack_seen;
        issue_next    = 1'b0;
        id_next       = issue_id;
        timeout_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    issue_next    = 1'b1;
                    id_next       = win;
                    ptr_next      = win;
                    gap_next      = GAP_W'(GAP_CYCLES - 2);
                    ack_next      = ACK_W'(ACK_TIMEOUT - 1);
                    ack_seen_next = 1'b0;
                    state_next    = GAP;
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_next = gap_cnt - GAP_W'(1);
                end
                if (ack_cnt != '0) begin
                    ack_next = ack_cnt - ACK_W'(1);
                end
                if (ack_pulse) begin
                    ack_seen_next = 1'b1;
                end
                if (gap_cnt == '0) begin
                    if (USE_ACK == 0 || ack_seen || ack_pulse) begin
                        state_next = IDLE;
                    end else begin
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                if (ack_cnt != '0) begin
                    ack_next = ack_cnt - ACK_W'(1);
                end
                if (ack_pulse) begin
                    state_next = IDLE;
                end else if (ack_cnt == '0) begin
                    // Acknowledge never came: drop the event, do not retry.
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and all outputs registered; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            ptr           <= IDW'(NUM_REQ - 1);
            gap_cnt       <= '0;
            ack_cnt       <= '0;
            ack_seen      <= 1'b0;
            issue_pulse   <= 1'b0;
            issue_id      <= '0;
            pending_any   <= 1'b0;
            busy          <= 1'b0;
            overflow      <= '0;
            timeout_pulse <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state         <= state_next;
            ptr           <= ptr_next;
            gap_cnt       <= gap_next;
            ack_cnt       <= ack_next;
            ack_seen      <= ack_seen_next;
            issue_pulse   <= issue_next;
            issue_id      <= id_next;
            pending_any   <= any_next;
            busy          <= (state_next != IDLE);
            overflow      <= ovf_next;
            timeout_pulse <= timeout_next;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_cdc_pulse_pacer.sv
// Testbench for cdc_pulse_pacer: one instance without ack, one with ack.
module tb_cdc_pulse_pacer;

    logic       clk;
    logic       rstn;
    logic [3:0] req_m;
    logic       clr_m;
    logic       ack_m;
    logic       iss_m;
    logic [1:0] id_m;
    logic       pend_m;
    logic       busy_m;
    logic [3:0] ovf_m;
    logic       to_m;
    logic [3:0] req_a;
    logic       clr_a;
    logic       ack_a;
    logic       iss_a;
    logic [1:0] id_a;
    logic       pend_a;
    logic       busy_a;
    logic [3:0] ovf_a;
    logic       to_a;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic       iss;
        logic [1:0] id;
        logic       busy;
        logic       pend;
    } vec_t;

    vec_t tab[$];

    cdc_pulse_pacer #(.NUM_REQ(4), .CNT_W(4), .GAP_CYCLES(8), .USE_ACK(0), .ACK_TIMEOUT(64)) u_dut (
        .clk(clk), .rstn(rstn), .req_pulse(req_m), .ovf_clear(clr_m), .ack_pulse(ack_m),
        .issue_pulse(iss_m), .issue_id(id_m), .pending_any(pend_m), .busy(busy_m),
        .overflow(ovf_m), .timeout_pulse(to_m)
    );

    cdc_pulse_pacer #(.NUM_REQ(4), .CNT_W(4), .GAP_CYCLES(8), .USE_ACK(1), .ACK_TIMEOUT(64)) u_ack (
        .clk(clk), .rstn(rstn), .req_pulse(req_a), .ovf_clear(clr_a), .ack_pulse(ack_a),
        .issue_pulse(iss_a), .issue_id(id_a), .pending_any(pend_a), .busy(busy_a),
        .overflow(ovf_a), .timeout_pulse(to_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic i, input logic [1:0] d, input logic b, input logic p);
        vec_t v;
        v.req = r; v.iss = i; v.id = d; v.busy = b; v.pend = p;
        tab.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [3:0] r, input logic i, input logic [1:0] d,
                         input logic b, input logic p);
        for (int k = 0; k < n; k++) add(r, i, d, b, p);
    endtask

    task automatic idle_inputs();
        req_m = '0; clr_m = 1'b0; ack_m = 1'b0;
        req_a = '0; clr_a = 1'b0; ack_a = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic run_table(input string tag, input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            @(posedge clk); #1;
            req_m = tab[k].req;
            @(negedge clk);
            chk($sformatf("%s[%0d].issue", tag, k - lo), 32'(iss_m), 32'(tab[k].iss));
            chk($sformatf("%s[%0d].id", tag, k - lo), 32'(id_m), 32'(tab[k].id));
            chk($sformatf("%s[%0d].busy", tag, k - lo), 32'(busy_m), 32'(tab[k].busy));
            chk($sformatf("%s[%0d].pend", tag, k - lo), 32'(pend_m), 32'(tab[k].pend));
            chk($sformatf("%s[%0d].ovf", tag, k - lo), 32'(ovf_m), 32'h0);
        end
    endtask

    initial begin
        int t1_end;
        int t2_end;
        int ids[$];
        int cyc[$];
        int tos[$];
        int n0;
        int nbad;
        int n2;

        rstn = 1'b0;
        idle_inputs();

        // single request on id 1 from reset
        add(4'b0010, 0, 0, 0, 0);
        add(4'b0000, 0, 0, 0, 1);
        add(4'b0000, 1, 1, 1, 0);
        add_n(6, 4'b0000, 0, 1, 1, 0);
        add_n(2, 4'b0000, 0, 1, 0, 0);
        t1_end = tab.size();
        // all four at once, round-robin from id 0, 8 cycles apart
        add(4'b1111, 0, 0, 0, 0);
        add(4'b0000, 0, 0, 0, 1);
        add(4'b0000, 1, 0, 1, 1);
        add_n(6, 4'b0000, 0, 0, 1, 1);
        add(4'b0000, 0, 0, 0, 1);
        add(4'b0000, 1, 1, 1, 1);
        add_n(6, 4'b0000, 0, 1, 1, 1);
        add(4'b0000, 0, 1, 0, 1);
        add(4'b0000, 1, 2, 1, 1);
        add_n(6, 4'b0000, 0, 2, 1, 1);
        add(4'b0000, 0, 2, 0, 1);
        add(4'b0000, 1, 3, 1, 0);
        add_n(6, 4'b0000, 0, 3, 1, 0);
        add_n(7, 4'b0000, 0, 3, 0, 0);
        t2_end = tab.size();

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.issue_m", 32'(iss_m), 0);
        chk("rst.id_m", 32'(id_m), 0);
        chk("rst.pend_m", 32'(pend_m), 0);
        chk("rst.busy_m", 32'(busy_m), 0);
        chk("rst.ovf_m", 32'(ovf_m), 0);
        chk("rst.to_m", 32'(to_m), 0);
        chk("rst.issue_a", 32'(iss_a), 0);
        chk("rst.id_a", 32'(id_a), 0);
        chk("rst.pend_a", 32'(pend_a), 0);
        chk("rst.busy_a", 32'(busy_a), 0);
        chk("rst.ovf_a", 32'(ovf_a), 0);
        chk("rst.to_a", 32'(to_a), 0);

        do_reset();
        run_table("single", 0, t1_end);
        do_reset();
        run_table("all4", t1_end, t2_end);

        // req 0 every cycle for 12 cycles plus one req 3 pulse
        do_reset();
        ids.delete(); cyc.delete();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            req_m = 4'b0000;
            req_m[0] = (c < 12);
            req_m[3] = (c == 0);
            @(negedge clk);
            if (iss_m) begin
                ids.push_back(int'(id_m));
                cyc.push_back(c);
            end
        end
        chk("hold0.count", 32'(ids.size()), 13);
        if (ids.size() == 13) begin
            chk("hold0.id0", 32'(ids[0]), 0);
            chk("hold0.id1", 32'(ids[1]), 3);
            chk("hold0.first_cycle", 32'(cyc[0]), 2);
            n0 = 0;
            nbad = 0;
            for (int k = 2; k < 13; k++) begin
                if (ids[k] == 0) n0++;
                if (cyc[k] - cyc[k-1] != 8) nbad++;
            end
            chk("hold0.zeros_after_3", 32'(n0), 11);
            chk("hold0.spacing_errs", 32'(nbad), 0);
            chk("hold0.second_cycle", 32'(cyc[1]), 10);
        end

        // reset during GAP with three events pending on id 1
        do_reset();
        n0 = 0;
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            req_m = (c <= 3) ? 4'b0010 : 4'b0000;
            rstn  = (c == 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c == 2) begin
                chk("midrst.first_issue", 32'(iss_m), 1);
                chk("midrst.first_id", 32'(id_m), 1);
            end
            if (c == 4) chk("midrst.pend_before", 32'(pend_m), 1);
            if (c == 6) begin
                chk("midrst.busy_after", 32'(busy_m), 0);
                chk("midrst.pend_after", 32'(pend_m), 0);
            end
            if (c >= 3 && iss_m) n0++;
        end
        chk("midrst.late_issues", 32'(n0), 0);

        // ack mode: early ack, late ack, then no ack (timeouts)
        do_reset();
        cyc.delete(); tos.delete(); ids.delete();
        for (int c = 0; c < 170; c++) begin
            @(posedge clk); #1;
            req_a = (c <= 3) ? 4'b0001 : 4'b0000;
            ack_a = (c == 5 || c == 30);
            @(negedge clk);
            if (iss_a) begin
                cyc.push_back(c);
                ids.push_back(int'(id_a));
            end
            if (to_a) tos.push_back(c);
        end
        chk("ack.issue_count", 32'(cyc.size()), 4);
        chk("ack.timeout_count", 32'(tos.size()), 2);
        if (cyc.size() == 4) begin
            chk("ack.issue0", 32'(cyc[0]), 2);
            chk("ack.issue_after_early_ack", 32'(cyc[1]), 10);
            chk("ack.issue_after_late_ack", 32'(cyc[2]), 32);
            chk("ack.issue_after_timeout", 32'(cyc[3]), 97);
            chk("ack.id", 32'(ids[3]), 0);
        end
        if (tos.size() == 2) begin
            chk("ack.timeout0", 32'(tos[0]), 96);
            chk("ack.timeout1", 32'(tos[1]), 161);
        end

        // saturation and overflow on req 2 while waiting for an ack
        do_reset();
        cyc.delete(); ids.delete();
        n2 = 0;
        nbad = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            req_a = 4'b0000;
            req_a[1] = (c == 0);
            req_a[2] = (c >= 5 && c <= 20) || (c == 30);
            clr_a = (c == 25 || c == 30);
            ack_a = (c >= 31);
            @(negedge clk);
            if (c == 20) chk("ovf.before_16th", 32'(ovf_a), 0);
            if (c == 21) chk("ovf.after_16th", 32'(ovf_a), 32'h4);
            if (c == 25) chk("ovf.sticky", 32'(ovf_a), 32'h4);
            if (c == 26) chk("ovf.cleared", 32'(ovf_a), 0);
            if (c == 31) chk("ovf.clear_priority", 32'(ovf_a), 0);
            if (to_a) nbad++;
            if (iss_a) begin
                cyc.push_back(c);
                ids.push_back(int'(id_a));
                if (id_a == 2'd2) n2++;
            end
        end
        chk("ovf.total_issues", 32'(cyc.size()), 16);
        chk("ovf.id2_issues", 32'(n2), 15);
        chk("ovf.timeouts", 32'(nbad), 0);
        chk("ovf.pend_end", 32'(pend_a), 0);
        if (cyc.size() == 16) begin
            chk("ovf.first_id", 32'(ids[0]), 1);
            chk("ovf.first_id2_cycle", 32'(cyc[1]), 33);
            chk("ovf.last_cycle", 32'(cyc[15]), 145);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
